// File: rtl/bcci_axil_cfg_master.sv
// ---------------------------------------------------------------------------
// bcci_axil_cfg_master
//
// AXI4-Lite initiator driving the bcci_ip control register file from a simple
// command/response handshake. One transaction is outstanding at a time. A
// transaction that stays outstanding for TIMEOUT_CYCLES cycles is abandoned,
// reported with SLVERR and a timeout flag, and the block then parks in a
// sticky error state until reset.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_*                 command request (valid/ready, write, addr, wdata, wstrb)
//   rsp_*                 response (valid/ready, rdata, resp, timeout)
//   err                   sticky timeout flag
//   m_axi_aw*/w*/b*       AXI4-Lite write address / data / response channels
//   m_axi_ar*/r*          AXI4-Lite read address / data channels
// ---------------------------------------------------------------------------
module bcci_axil_cfg_master #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,

    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic                          cmd_write,
    input  logic [AXI_ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [AXI_DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [AXI_DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                    rsp_resp,
    output logic                          rsp_timeout,
    output logic                          err,

    output logic                          m_axi_awvalid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                    m_axi_awprot,
    input  logic                          m_axi_awready,
    output logic                          m_axi_wvalid,
    output logic [AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    input  logic                          m_axi_wready,
    input  logic                          m_axi_bvalid,
    input  logic [1:0]                    m_axi_bresp,
    output logic                          m_axi_bready,

    output logic                          m_axi_arvalid,
    output logic [AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                    m_axi_arprot,
    input  logic                          m_axi_arready,
    input  logic                          m_axi_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    output logic                          m_axi_rready
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP,
        S_ERR
    } state_t;

    state_t                        state_q, state_d;
    logic                          ready_en_q;
    logic                          aw_done_q;
    logic                          w_done_q;
    logic [CNT_W-1:0]              cnt_q;
    logic [AXI_ADDR_WIDTH-1:0]     addr_q;
    logic [AXI_DATA_WIDTH-1:0]     wdata_q;
    logic [AXI_DATA_WIDTH/8-1:0]   wstrb_q;
    logic [AXI_DATA_WIDTH-1:0]     rdata_q;
    logic [1:0]                    resp_q;
    logic                          timeout_q;
    logic                          err_q;

    logic accept;
    logic aw_hs;
    logic w_hs;
    logic terminal;
    logic capture_b;
    logic capture_r;
    logic fire_timeout;
    logic busy;

    // Channel handshakes only count while the matching valid is actually up.
    assign aw_hs    = (state_q == S_WADDR) && !aw_done_q && m_axi_awready;
    assign w_hs     = (state_q == S_WADDR) && !w_done_q  && m_axi_wready;
    assign terminal = (cnt_q == CNT_TERM);
    assign busy     = (state_q == S_WADDR) || (state_q == S_WRESP) ||
                      (state_q == S_RADDR) || (state_q == S_RDATA);

    // Next-state logic. In every busy state the normal exit is tested first,
    // so a handshake landing on the terminal count still completes normally.
    always_comb begin
        state_d      = state_q;
        accept       = 1'b0;
        capture_b    = 1'b0;
        capture_r    = 1'b0;
        fire_timeout = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ready_en_q && cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_write ? S_WADDR : S_RADDR;
                end
            end
            S_WADDR: begin
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) begin
                    state_d = S_WRESP;
                end else if (terminal) begin
                    fire_timeout = 1'b1;
                    state_d      = S_RSP;
                end
            end
            S_WRESP: begin
                if (m_axi_bvalid) begin
                    capture_b = 1'b1;
                    state_d   = S_RSP;
                end else if (terminal) begin
                    fire_timeout = 1'b1;
                    state_d      = S_RSP;
                end
            end
            S_RADDR: begin
                if (m_axi_arready) begin
                    state_d = S_RDATA;
                end else if (terminal) begin
                    fire_timeout = 1'b1;
                    state_d      = S_RSP;
                end
            end
            S_RDATA: begin
                if (m_axi_rvalid) begin
                    capture_r = 1'b1;
                    state_d   = S_RSP;
                end else if (terminal) begin
                    fire_timeout = 1'b1;
                    state_d      = S_RSP;
                end
            end
            S_RSP: begin
                // err is only ever set by a timeout, so it tells us whether the
                // response being consumed was the timeout one.
                if (rsp_ready) begin
                    state_d = err_q ? S_ERR : S_IDLE;
                end
            end
            S_ERR: begin
                state_d = S_ERR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // cmd_ready is held low for the first cycle out of reset so that every
    // output reads 0 while rst_n is asserted even though the state is IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en_q <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
        end
    end

    // AW and W are tracked separately so each valid drops on its own handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (accept) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs)  w_done_q  <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (accept) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q   <= '0;
            resp_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (fire_timeout) begin
            rdata_q   <= '0;
            resp_q    <= RESP_SLVERR;
            timeout_q <= 1'b1;
            err_q     <= 1'b1;
        end else if (capture_b) begin
            rdata_q   <= '0;
            resp_q    <= m_axi_bresp;
            timeout_q <= 1'b0;
        end else if (capture_r) begin
            rdata_q   <= m_axi_rdata;
            resp_q    <= m_axi_rresp;
            timeout_q <= 1'b0;
        end
    end

    // Outputs decode from registered state only; nothing combinational from
    // the AXI inputs reaches the outputs.
    assign cmd_ready     = (state_q == S_IDLE) && ready_en_q;
    assign rsp_valid     = (state_q == S_RSP);
    assign rsp_rdata     = rdata_q;
    assign rsp_resp      = resp_q;
    assign rsp_timeout   = timeout_q;
    assign err           = err_q;

    assign m_axi_awvalid = (state_q == S_WADDR) && !aw_done_q;
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_wvalid  = (state_q == S_WADDR) && !w_done_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_bready  = (state_q == S_WRESP);

    assign m_axi_arvalid = (state_q == S_RADDR);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_rready  = (state_q == S_RDATA);

endmodule

// File: tb/tb_bcci_axil_cfg_master.sv
module tb_bcci_axil_cfg_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic        rsp_timeout, err;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic [31:0] awaddr, wdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;
    logic        arvalid, arready, rvalid, rready;
    logic [31:0] araddr, rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcci_axil_cfg_master #(
        .AXI_DATA_WIDTH(32),
        .AXI_ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .err(err),
        .m_axi_awvalid(awvalid), .m_axi_awaddr(awaddr), .m_axi_awprot(awprot),
        .m_axi_awready(awready),
        .m_axi_wvalid(wvalid), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wready(wready),
        .m_axi_bvalid(bvalid), .m_axi_bresp(bresp), .m_axi_bready(bready),
        .m_axi_arvalid(arvalid), .m_axi_araddr(araddr), .m_axi_arprot(arprot),
        .m_axi_arready(arready),
        .m_axi_rvalid(rvalid), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rready(rready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and park on the falling edge (inputs driven and
    // outputs sampled there).
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic slave_idle();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
    endtask

    task automatic put_cmd(input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    endtask

    task automatic no_cmd();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0; cmd_wstrb = 4'h0;
    endtask

    initial begin
        rst_n = 1'b0;
        rsp_ready = 1'b0;
        no_cmd();
        slave_idle();

        // ---------------- reset state ----------------
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_awvalid", awvalid, 0);
        chk("rst_arvalid", arvalid, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_prot", {awprot, arprot}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_cmd_ready", cmd_ready, 1);

        // ---------------- zero-wait write ----------------
        put_cmd(1'b1, 32'h0000_0010, 32'h0000_0780, 4'hF);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();                                   // accept edge N
        no_cmd();
        chk("w1_awvalid", awvalid, 1);
        chk("w1_wvalid", wvalid, 1);
        chk("w1_awaddr", awaddr, 32'h10);
        chk("w1_wdata", wdata, 32'h780);
        chk("w1_wstrb", wstrb, 4'hF);
        chk("w1_cmd_ready", cmd_ready, 0);
        tick();                                   // AW/W at N+1
        chk("w1_wresp_awvalid", awvalid, 0);
        chk("w1_wresp_wvalid", wvalid, 0);
        chk("w1_bready", bready, 1);
        chk("w1_early_rsp", rsp_valid, 0);
        tick();                                   // B at N+2
        chk("w1_rsp_valid", rsp_valid, 1);
        chk("w1_rsp_resp", rsp_resp, 0);
        chk("w1_rsp_rdata", rsp_rdata, 0);
        chk("w1_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        slave_idle();
        tick();
        rsp_ready = 1'b0;
        chk("w1_done_rsp_valid", rsp_valid, 0);
        chk("w1_done_cmd_ready", cmd_ready, 1);

        // ---------------- AW two cycles before W ----------------
        put_cmd(1'b1, 32'h0000_0020, 32'h0000_1234, 4'h3);
        tick();
        no_cmd();
        chk("w2_c1_awvalid", awvalid, 1);
        chk("w2_c1_wvalid", wvalid, 1);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        chk("w2_c2_awvalid", awvalid, 0);
        chk("w2_c2_wvalid", wvalid, 1);
        tick();
        chk("w2_c3_awvalid", awvalid, 0);
        chk("w2_c3_wvalid", wvalid, 1);
        chk("w2_c3_wdata", wdata, 32'h1234);
        chk("w2_c3_bready", bready, 0);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        chk("w2_c4_wvalid", wvalid, 0);
        chk("w2_c4_bready", bready, 1);
        bvalid = 1'b1;
        tick();
        bvalid = 1'b0;
        chk("w2_rsp_valid", rsp_valid, 1);
        chk("w2_bready_after_b", bready, 0);
        chk("w2_awvalid_after_b", awvalid, 0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("w2_single_rsp", rsp_valid, 0);
        chk("w2_cmd_ready", cmd_ready, 1);

        // ---------------- read with wait states and stalled response ----------------
        put_cmd(1'b0, 32'h0000_0004, 32'h0, 4'h0);
        tick();
        no_cmd();
        chk("r1_arvalid", arvalid, 1);
        chk("r1_araddr", araddr, 32'h4);
        chk("r1_awvalid", awvalid, 0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk("r1_arvalid_drop", arvalid, 0);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("r1_wait%0d_rready", i), rready, 1);
            chk($sformatf("r1_wait%0d_rsp_valid", i), rsp_valid, 0);
            tick();
        end
        rvalid = 1'b1; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
        tick();
        rvalid = 1'b0; rdata = 32'h5555_AAAA; rresp = 2'b11;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("r1_hold%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("r1_hold%0d_rdata", i), rsp_rdata, 32'hDEAD_BEEF);
            chk($sformatf("r1_hold%0d_resp", i), rsp_resp, 0);
            chk($sformatf("r1_hold%0d_cmd_ready", i), cmd_ready, 0);
            chk($sformatf("r1_hold%0d_rready", i), rready, 0);
            tick();
        end
        rsp_ready = 1'b1;
        chk("r1_last_cmd_ready", cmd_ready, 0);
        chk("r1_last_rdata", rsp_rdata, 32'hDEAD_BEEF);
        tick();
        rsp_ready = 1'b0;
        chk("r1_after_cmd_ready", cmd_ready, 1);
        chk("r1_after_rsp_valid", rsp_valid, 0);
        rdata = 32'h0; rresp = 2'b00;

        // ---------------- SLVERR write response pass-through ----------------
        put_cmd(1'b1, 32'h0000_0008, 32'hA5A5_0001, 4'h1);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b10;
        tick();
        no_cmd();
        tick();
        tick();
        chk("e1_rsp_valid", rsp_valid, 1);
        chk("e1_rsp_resp", rsp_resp, 2'b10);
        chk("e1_rsp_timeout", rsp_timeout, 0);
        chk("e1_err", err, 0);
        rsp_ready = 1'b1;
        slave_idle();
        tick();
        rsp_ready = 1'b0;
        chk("e1_cmd_ready", cmd_ready, 1);

        // ---------------- read timeout (arready never rises) ----------------
        put_cmd(1'b0, 32'h0000_000C, 32'h0, 4'h0);
        tick();
        no_cmd();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("t1_c%0d_arvalid", i), arvalid, 1);
            tick();
        end
        chk("t1_arvalid_drop", arvalid, 0);
        chk("t1_rready", rready, 0);
        chk("t1_rsp_valid", rsp_valid, 1);
        chk("t1_rsp_timeout", rsp_timeout, 1);
        chk("t1_rsp_resp", rsp_resp, 2'b10);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_err", err, 1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        put_cmd(1'b1, 32'h0000_0010, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t1_err%0d_cmd_ready", i), cmd_ready, 0);
            chk($sformatf("t1_err%0d_rsp_valid", i), rsp_valid, 0);
            chk($sformatf("t1_err%0d_awvalid", i), awvalid, 0);
            chk($sformatf("t1_err%0d_arvalid", i), arvalid, 0);
            chk($sformatf("t1_err%0d_err", i), err, 1);
            tick();
        end
        no_cmd();

        // ---------------- reset clears error ----------------
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("x1_err", err, 0);
        chk("x1_cmd_ready", cmd_ready, 1);

        // ---------------- asynchronous reset while in WRESP ----------------
        put_cmd(1'b1, 32'h0000_0030, 32'h0000_0033, 4'hF);
        awready = 1'b1; wready = 1'b1;
        tick();
        no_cmd();
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("x2_bready", bready, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("x2_async_bready", bready, 0);
        chk("x2_async_cmd_ready", cmd_ready, 0);
        chk("x2_async_awaddr", awaddr, 0);
        chk("x2_async_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        chk("x2_in_rst_awvalid", awvalid, 0);
        rst_n = 1'b1;
        tick();
        chk("x2_post_cmd_ready", cmd_ready, 1);
        chk("x2_post_rsp_valid", rsp_valid, 0);
        put_cmd(1'b1, 32'h0000_0040, 32'h0000_0044, 4'hC);
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
        tick();
        no_cmd();
        chk("x3_awaddr", awaddr, 32'h40);
        chk("x3_wstrb", wstrb, 4'hC);
        tick();
        tick();
        chk("x3_rsp_valid", rsp_valid, 1);
        chk("x3_rsp_resp", rsp_resp, 0);
        chk("x3_rsp_timeout", rsp_timeout, 0);
        rsp_ready = 1'b1;
        slave_idle();
        tick();
        rsp_ready = 1'b0;
        chk("x3_cmd_ready", cmd_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
